// File: rtl/mdu_hilo_if.sv
// Command/result bundle between the EX stage and the mdu_hilo multiply/divide unit.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Defining MDU_FAST_MUL_EN makes MULT/MULTU single-edge via '*'; divide stays iterative.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  mdu_hilo_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting; MTHI/MTLO writes and start accepted here
  // MUL   | radix-2 shift-add, one multiplier bit per edge
  // DIV   | restoring division, one quotient bit per edge
  // FIX   | sign correction and HI/LO write, done pulse follows
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_t             state_q;
  logic [5:0]         cnt_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rneg_q;
  logic               div0_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               fast_hit;
  logic [2*WIDTH-1:0] fast_prod;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
`endif

  always_comb begin
    accept    = (state_q == S_IDLE) & bus.start & ~bus.flush & ~bus.hi_we & ~bus.lo_we;
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    mul_d     = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Partial remainder is always below twice the divisor, so WIDTH+1 bits hold the trial.
    div_shift = {acc_q, 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, mcand_q};
    div_d     = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    prod_fix  = neg_q ? -acc_q : acc_q;
    quot_fix  = div0_q ? {WIDTH{1'b1}}
                       : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
    // Low 2W bits of the extended product equal the signed product modulo 2^2W.
    a_ext     = {{WIDTH{a_neg}}, bus.a};
    b_ext     = {{WIDTH{b_neg}}, bus.b};
    fast_prod = a_ext * b_ext;
    fast_hit  = accept & ~bus.op[1];
`else
    fast_prod = '0;
    fast_hit  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (fast_hit) begin
            hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
            lo_q   <= fast_prod[WIDTH-1:0];
            done_q <= 1'b1;
          end else if (accept) begin
            cnt_q    <= '0;
            is_div_q <= bus.op[1];
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            div0_q   <= bus.op[1] & (bus.b == '0);
            mcand_q  <= bus.op[1] ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
            state_q  <= bus.op[1] ? S_DIV : S_MUL;
            busy_q   <= 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= (state_q == S_DIV) ? div_d : mul_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit with the architectural HI/LO registers for the pipelined MIPS core. Sits in EX beside the ALU; its `hi`/`lo` outputs feed the EX result-select mux4 (MFHI/MFLO path). `busy` drives the hazard logic, which stalls IF/ID/EX while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  launch the operation selected by `op` (sampled on a clock edge).
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b`  in  WIDTH  operands (rs, rt); captured at the accepting edge.
- `flush`  in  1  abort any in-flight operation.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight (registered).
- `done`  out  1  one-cycle pulse; new HI/LO are visible in that same cycle.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.

## Operation
- FSM states: IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).
- IDLE: on `start` with no `flush` and no `hi_we`/`lo_we`, latch operand magnitudes (abs for signed ops), result-sign flags and op type. Clear the 6-bit iteration counter. Go to MUL or DIV.
- MUL: radix-2 shift-add, 32 iterations, 2W-bit accumulator. Then go to FIX.
- DIV: restoring division, 32 iterations. Each iteration shifts the remainder left, trial-subtracts, and sets one quotient bit. Then go to FIX.
- FIX: apply sign correction, write HI/LO, assert `done` for the following cycle, go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negative if the signs differ; remainder takes the sign of the dividend.
- Results: multiply gives HI = product[63:32], LO = product[31:0]. Divide gives LO = quotient, HI = remainder.
- Divide by zero (`b` = 0): LO = all ones, HI = dividend. This holds for both signed and unsigned ops. The 32-cycle latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm.
- `hi_we`/`lo_we` in IDLE: write `wdata` at the next edge. If `start` is asserted in the same cycle, the write wins and `start` is ignored.
- `hi_we`/`lo_we`/`start` while busy: ignored. Upstream must hold the instruction stalled.
- `flush` while busy: next edge returns to IDLE. HI/LO unchanged, no `done`.
- `flush` in IDLE: `start` in the same cycle is ignored. An MTHI/MTLO write in that same cycle is still performed.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0, state IDLE, counter 0.
- Assertion of `rst` aborts any operation immediately, with no clock needed.
- Edges: start accepted at edge E0; iterations at E1..E32; FIX writes HI/LO at E33.
- Latency is 33 edges.
  - `busy` is high from after E0 through before E33.
  - After E33: `done` = 1, `busy` = 0 and new `hi`/`lo` are valid.
- A new `start` is accepted at E33's following edge (back-to-back at 34-cycle throughput).
- MTHI/MTLO: the new value is visible the cycle after the write edge. `done` is not pulsed.
- Outputs are all registered, with no combinational input-to-output path.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU complete in 1 edge. The signed/unsigned 2W-bit product uses the `*` operator and is written to HI/LO at E0.
  - `done` is high in the cycle after E0 and `busy` never asserts for multiplies.
  - Divide is unaffected.
- Undefined: the iterative MUL state is used, with 33-edge latency as above.

## Test plan
- Reset mid-DIV: assert `rst` at cycle 10 of DIV 100/7 -> `busy`/`done`/`hi`/`lo` = 0 immediately; the next DIVU 100/7 gives LO = 14, HI = 2 with `done` at E33.
- Signed divide: DIV -7/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO = 0x80000000, HI = 0. DIVU 5/0 -> LO = 0xFFFFFFFF, HI = 5.
- Multiply:
  - MULT 0xFFFFFFFF × 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
  - MULTU 0xFFFFFFFF × 2 -> HI = 1, LO = 0xFFFFFFFE.
  - Latency is checked as 33 edges, or 1 edge with `MDU_FAST_MUL_EN`.
- Flush: `flush` at cycle 5 of DIVU 9/3 after HI/LO preloaded with 0xA/0xB -> IDLE next edge, no `done`, HI/LO stay 0xA/0xB.
- Collisions:
  - `start` while busy -> ignored; the result matches the first operation only.
  - `start` + `hi_we` (`wdata` = 0x1234) in IDLE -> HI = 0x1234, `busy` stays 0.
  - `start` + `flush` -> no operation starts.
- Back-to-back: DIVU 20/3, then `start` MULTU 6×7 in the first cycle `busy` = 0 -> two `done` pulses; final HI = 0, LO = 42.
